// File: rtl/acc_fifo_reader_pkg.sv
// Shared constants and state encoding for the ACC FIFO read path.
// Widths are shared with the FIFO and the engine top.
package acc_fifo_reader_pkg;

    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACC_LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    function automatic logic state_is_busy(input rd_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/acc_out_stage.sv
// One-deep valid/ready output register for popped accumulator words.
// With ACC_RELU_EN defined, negative (two's-complement) words are clamped to zero on load.
module acc_out_stage #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 clk_en,
    input  logic                 load,
    input  logic [DataWidth-1:0] load_data,
    input  logic                 load_last,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_last
);

    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [DataWidth-1:0] load_val;

`ifdef ACC_RELU_EN
    // Clamp negative words to zero before they reach the output register.
    always_comb begin
        if (load_data[DataWidth-1]) begin
            load_val = {DataWidth{1'b0}};
        end else begin
            load_val = load_data;
        end
    end
`else
    // Words pass through unmodified.
    always_comb begin
        load_val = load_data;
    end
`endif

    // Next-state of the output register: a load wins over a completing handshake.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = load_last;
            data_d  = load_val;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            valid_d = valid_q;
            last_d  = last_q;
        end
    end

    // Output register with synchronous reset and clock-enable freeze.
    always_ff @(posedge clk) begin
        if (aclr) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= {DataWidth{1'b0}};
        end else if (clk_en) begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/acc_fifo_reader.sv
// Read-side controller of the accumulator-result FIFO: drains Length words per job into
// a valid/ready output stage and pulses Done. Optional macro ACC_RELU_EN clamps negatives.
module acc_fifo_reader
    import acc_fifo_reader_pkg::*;
#(
    parameter int DataWidth = ACC_DATA_WIDTH,
    parameter int LenWidth  = ACC_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 clk_en,
    input  logic                 Start,
    input  logic [LenWidth-1:0]  Length,
    input  logic                 FifoEmpty,
    input  logic [DataWidth-1:0] FifoData,
    output logic                 FifoPop,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] OutData,
    output logic                 OutLast,
    output logic                 Busy,
    output logic                 Done
);

    localparam logic [LenWidth-1:0] LEN_ZERO = LenWidth'(0);
    localparam logic [LenWidth-1:0] LEN_ONE  = LenWidth'(1);

    rd_state_e            state_q, state_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fifo_pop;
    logic                 out_valid;
    logic                 out_last;
    logic [DataWidth-1:0] out_data;
    logic                 handshake;

    assign handshake = out_valid & OutReady;

    // Job sequencing; a pop needs remaining!=0, so the counter can never wrap below zero.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Length != LEN_ZERO) begin
                        remaining_d = Length;
                        state_d     = ST_DRAIN;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                fifo_pop = clk_en & ~FifoEmpty & (remaining_q != LEN_ZERO)
                         & (~out_valid | OutReady);
                if (fifo_pop) begin
                    remaining_d = remaining_q - LEN_ONE;
                end else begin
                    remaining_d = remaining_q;
                end
                if (remaining_d == LEN_ZERO) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (handshake) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = state_is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and registered status flags; clk_en low freezes everything but reset.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q     <= ST_IDLE;
            remaining_q <= LEN_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    acc_out_stage #(
        .DataWidth (DataWidth)
    ) u_out_stage (
        .clk       (clk),
        .aclr      (aclr),
        .clk_en    (clk_en),
        .load      (fifo_pop),
        .load_data (FifoData),
        .load_last (remaining_q == LEN_ONE),
        .out_ready (OutReady),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign FifoPop  = fifo_pop;
    assign OutValid = out_valid;
    assign OutData  = out_data;
    assign OutLast  = out_last;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_acc_fifo_reader.sv
// Scoreboard bench for acc_fifo_reader: a queue-based FIFO model feeds the DUT, expected
// words are queued per job and a negedge monitor compares every handshake and hold period.
module tb_acc_fifo_reader;

    logic        clk = 1'b0;
    logic        aclr, clk_en, Start, FifoEmpty, FifoPop, OutValid, OutReady, OutLast, Busy, Done;
    logic [15:0] Length;
    logic [31:0] FifoData, OutData;

    acc_fifo_reader dut (
        .clk(clk), .aclr(aclr), .clk_en(clk_en), .Start(Start), .Length(Length),
        .FifoEmpty(FifoEmpty), .FifoData(FifoData), .FifoPop(FifoPop),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic [31:0] fifo_q[$];
    logic [31:0] job_w[$];
    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    logic        pop_pend = 1'b0;
    logic        hold_prev = 1'b0;
    logic [35:0] prev_vec = 36'd0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] w);
`ifdef ACC_RELU_EN
        return ($signed(w) < 0) ? 32'd0 : w;
`else
        return w;
`endif
    endfunction

    task automatic drive_fifo();
        FifoEmpty = (fifo_q.size() == 0);
        FifoData  = (fifo_q.size() == 0) ? 32'd0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // Advance one clock edge and apply the FIFO side effects of that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (aclr) fifo_q.delete();
        else if (pop_pend) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic expect_job();
        for (int i = 0; i < job_w.size(); i++)
            exp_q.push_back('{data: ref_word(job_w[i]), last: (i == job_w.size() - 1)});
    endtask

    task automatic gen_words(input int len);
        job_w.delete();
        for (int i = 0; i < len; i++) job_w.push_back($urandom);
    endtask

    task automatic start_job(input int len);
        clk_en = 1'b1;
        Start  = 1'b1;
        Length = 16'(len);
        done_exp++;
        tick();
        Start  = 1'b0;
        Length = 16'($urandom);
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (done_cnt < done_exp && cyc < 300) begin
            tick();
            cyc++;
        end
        chk(name, 64'(done_cnt), 64'(done_exp));
    endtask

    // Monitor: scoreboard pops on handshakes, hold/stall rules, Done bookkeeping.
    always @(negedge clk) begin
        if (hold_prev) chk("hold", 64'({Busy, Done, OutValid, OutLast, OutData}), 64'(prev_vec));
        if (!aclr) begin
            if (!clk_en) begin
                chk("pop_clken_low", 64'(FifoPop), 64'd0);
            end else begin
                if (OutValid && !OutReady) chk("pop_in_stall", 64'(FifoPop), 64'd0);
                if (OutValid && OutReady) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_word: got %0h want none", OutData);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", 64'({OutLast, OutData}), 64'({e.last, e.data}));
                    end
                end
                if (Done) begin
                    done_cnt++;
                    chk("done_after_all_words", 64'(exp_q.size()), 64'd0);
                    chk("done_out_empty", 64'(OutValid), 64'd0);
                end
            end
        end
        hold_prev = !aclr && (!clk_en || (OutValid && !OutReady));
        prev_vec  = {Busy, Done, OutValid, OutLast, OutData};
        pop_pend  = FifoPop;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int len, pre, idx, cyc;
        aclr = 1'b1; clk_en = 1'b0; Start = 1'b0; Length = 16'd0; OutReady = 1'b1;
        drive_fifo();
        tick(); tick();
        @(negedge clk);
        chk("reset_outs", 64'({FifoPop, OutValid, OutLast, Busy, Done, OutData}), 64'd0);
        aclr = 1'b0; clk_en = 1'b1;
        tick();

        // Stream of four words with OutReady held high.
        job_w = '{32'd5, 32'd6, 32'd7, 32'd8};
        foreach (job_w[i]) push(job_w[i]);
        expect_job();
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_pop", 64'(FifoPop), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("stream_flush", 64'({FifoPop, Done, OutValid, OutLast, OutData}), 64'({3'b001, 1'b1, 32'd8}));
        tick();
        @(negedge clk);
        chk("stream_done_latency", 64'(Done), 64'd1);
        tick();
        @(negedge clk);
        chk("stream_idle", 64'({Busy, Done}), 64'd0);

        // Backpressure: stall three cycles after the first word.
        gen_words(3);
        foreach (job_w[i]) push(job_w[i]);
        expect_job();
        start_job(3);
        tick();
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_first", 64'({OutValid, OutData}), 64'({1'b1, ref_word(job_w[0])}));
            tick();
        end
        OutReady = 1'b1;
        wait_done("bp_done");

        // Starved FIFO: words trickle in.
        gen_words(2);
        expect_job();
        start_job(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("starve_wait", 64'({Busy, FifoPop}), 64'({1'b1, 1'b0}));
            tick();
        end
        push(job_w[0]);
        @(negedge clk);
        chk("starve_pop1", 64'(FifoPop), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("starve_busy", 64'({Busy, Done}), 64'({1'b1, 1'b0}));
        end
        tick();
        push(job_w[1]);
        @(negedge clk);
        chk("starve_pop2", 64'(FifoPop), 64'd1);
        wait_done("starve_done");

        // Length=0, with a clk_en freeze while Done is pending.
        job_w.delete();
        start_job(0);
        @(negedge clk);
        chk("len0_done", 64'({Done, FifoPop}), 64'({1'b1, 1'b0}));
        clk_en = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("len0_done_frozen", 64'(Done), 64'd1);
        clk_en = 1'b1;
        wait_done("len0_done_once");
        tick(); tick();
        chk("len0_no_extra_done", 64'(done_cnt), 64'(done_exp));

        // Start repeated while busy must be ignored.
        gen_words(2);
        foreach (job_w[i]) push(job_w[i]);
        expect_job();
        OutReady = 1'b0;
        start_job(2);
        tick();
        Start = 1'b1; Length = 16'd5;
        tick(); tick();
        Start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored", 64'(Busy), 64'd1);
        OutReady = 1'b1;
        wait_done("busy_start_done");
        tick(); tick(); tick();
        chk("busy_start_no_rejob", 64'({Busy, 32'(done_cnt)}), 64'({1'b0, 32'(done_exp)}));

        // clk_en low for two cycles mid-job.
        gen_words(3);
        foreach (job_w[i]) push(job_w[i]);
        expect_job();
        start_job(3);
        tick();
        clk_en = 1'b0;
        tick(); tick();
        clk_en = 1'b1;
        wait_done("clken_resume_done");

        // aclr during DRAIN discards the held word and the FIFO contents.
        gen_words(4);
        foreach (job_w[i]) push(job_w[i]);
        OutReady = 1'b0;
        start_job(4);
        done_exp--;
        tick();
        @(negedge clk);
        chk("aclr_pre_valid", 64'(OutValid), 64'd1);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        @(negedge clk);
        chk("aclr_outs", 64'({FifoPop, OutValid, OutLast, Busy, Done, OutData}), 64'd0);
        OutReady = 1'b1;
        tick();

        // Signed words for the optional clamp.
        job_w = '{32'hFFFF_FFF6, 32'h0000_000A};
        foreach (job_w[i]) push(job_w[i]);
        expect_job();
        start_job(2);
        wait_done("relu_done");

        // Randomized jobs: random lengths, data, trickle, backpressure and clk_en.
        for (int j = 0; j < 24; j++) begin
            len = $urandom_range(0, 6);
            gen_words(len);
            expect_job();
            pre = (len == 0) ? 0 : $urandom_range(0, len);
            for (int i = 0; i < pre; i++) push(job_w[i]);
            idx = pre;
            OutReady = $urandom_range(0, 1);
            start_job(len);
            cyc = 0;
            while (done_cnt < done_exp && cyc < 300) begin
                if (idx < len && $urandom_range(0, 1) == 1) begin
                    push(job_w[idx]);
                    idx++;
                end
                OutReady = ($urandom_range(0, 9) < 7);
                clk_en   = ($urandom_range(0, 9) != 0);
                tick();
                cyc++;
            end
            chk("rand_job_done", 64'(done_cnt), 64'(done_exp));
            clk_en = 1'b1;
            tick();
        end
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
